// File: rtl/speriph_plug_arbiter.sv
// Merges NB_PLUGS slave plugs onto one peripheral target, routing in-order responses back by FIFO.
// Define SPERIPH_PLUG_ARB_RR_EN for round-robin arbitration; otherwise the lowest requesting index wins.
module speriph_plug_arbiter #(
    parameter int unsigned NB_PLUGS        = 2,
    parameter int unsigned ID_WIDTH        = 5,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic [NB_PLUGS-1:0]                plug_req_i,
    input  logic [NB_PLUGS-1:0]                plug_wen_i,
    input  logic [NB_PLUGS-1:0][31:0]          plug_add_i,
    input  logic [NB_PLUGS-1:0][31:0]          plug_wdata_i,
    input  logic [NB_PLUGS-1:0][3:0]           plug_be_i,
    input  logic [NB_PLUGS-1:0][ID_WIDTH-1:0]  plug_id_i,
    output logic [NB_PLUGS-1:0]                plug_gnt_o,
    output logic [NB_PLUGS-1:0]                plug_r_valid_o,
    output logic [NB_PLUGS-1:0]                plug_r_opc_o,
    output logic [NB_PLUGS-1:0][31:0]          plug_r_rdata_o,
    output logic [NB_PLUGS-1:0][ID_WIDTH-1:0]  plug_r_id_o,
    output logic                               mst_req_o,
    output logic                               mst_wen_o,
    output logic [31:0]                        mst_add_o,
    output logic [31:0]                        mst_wdata_o,
    output logic [3:0]                         mst_be_o,
    output logic [ID_WIDTH-1:0]                mst_id_o,
    input  logic                               mst_gnt_i,
    input  logic                               mst_r_valid_i,
    input  logic                               mst_r_opc_i,
    input  logic [31:0]                        mst_r_rdata_i,
    input  logic [ID_WIDTH-1:0]                mst_r_id_i,
    output logic                               busy_o,
    output logic                               err_o
);

    localparam int unsigned IDX_W = (NB_PLUGS > 1) ? $clog2(NB_PLUGS) : 1;
    localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

    logic [IDX_W-1:0] r_fifo [MAX_OUTSTANDING];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_lock_vld;
    logic [IDX_W-1:0] r_lock_idx;
    logic             r_err;

    logic             w_any;
    logic             w_pop;
    logic             w_full;
    logic             w_hs;
    logic [IDX_W-1:0] w_win;
    logic [IDX_W-1:0] w_head;

`ifdef SPERIPH_PLUG_ARB_RR_EN
    logic [IDX_W-1:0] r_rr;
    logic [IDX_W-1:0] w_cand;
`endif

    assign w_any  = |plug_req_i;
    assign w_pop  = mst_r_valid_i && (r_count != '0);
    // A response popping this cycle frees a slot for a new request in the same cycle
    assign w_full = (r_count == CNT_W'(MAX_OUTSTANDING)) && !w_pop;
    assign w_hs   = mst_req_o && mst_gnt_i;
    assign w_head = r_fifo[r_rd_ptr];

    // Winner selection: a stalled request keeps its slot while its plug still requests
    always_comb begin
        w_win = '0;
`ifdef SPERIPH_PLUG_ARB_RR_EN
        w_cand = '0;
`endif
        if (r_lock_vld && plug_req_i[r_lock_idx]) begin
            w_win = r_lock_idx;
        end else begin
`ifdef SPERIPH_PLUG_ARB_RR_EN
            for (int k = int'(NB_PLUGS) - 1; k >= 0; k--) begin
                w_cand = IDX_W'((int'(r_rr) + k) % int'(NB_PLUGS));
                if (plug_req_i[w_cand]) begin
                    w_win = w_cand;
                end
            end
`else
            for (int i = int'(NB_PLUGS) - 1; i >= 0; i--) begin
                if (plug_req_i[i]) begin
                    w_win = IDX_W'(i);
                end
            end
`endif
        end
    end

    assign mst_req_o   = w_any && !w_full;
    assign mst_wen_o   = mst_req_o ? plug_wen_i[w_win]   : 1'b0;
    assign mst_add_o   = mst_req_o ? plug_add_i[w_win]   : 32'd0;
    assign mst_wdata_o = mst_req_o ? plug_wdata_i[w_win] : 32'd0;
    assign mst_be_o    = mst_req_o ? plug_be_i[w_win]    : 4'd0;
    assign mst_id_o    = mst_req_o ? plug_id_i[w_win]    : '0;

    // Grant fan-out and response routing to the plug at the FIFO head
    always_comb begin
        plug_gnt_o     = '0;
        plug_r_valid_o = '0;
        plug_r_opc_o   = '0;
        plug_r_rdata_o = '0;
        plug_r_id_o    = '0;
        for (int p = 0; p < int'(NB_PLUGS); p++) begin
            if (w_hs && (w_win == IDX_W'(p))) begin
                plug_gnt_o[p] = 1'b1;
            end
            if (w_pop && (w_head == IDX_W'(p))) begin
                plug_r_valid_o[p] = 1'b1;
                plug_r_opc_o[p]   = mst_r_opc_i;
                plug_r_rdata_o[p] = mst_r_rdata_i;
                plug_r_id_o[p]    = mst_r_id_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_hs) begin
            r_fifo[r_wr_ptr] <= w_win;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_lock_vld <= 1'b0;
            r_lock_idx <= '0;
            r_err      <= 1'b0;
        end else begin
            if (w_hs) begin
                r_wr_ptr <= (r_wr_ptr == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : r_rd_ptr + PTR_W'(1);
            end
            if (w_hs && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_hs && w_pop) begin
                r_count <= r_count - CNT_W'(1);
            end
            r_err <= mst_r_valid_i && (r_count == '0);
            if (w_hs) begin
                r_lock_vld <= 1'b0;
            end else if (mst_req_o) begin
                r_lock_vld <= 1'b1;
                r_lock_idx <= w_win;
            end else if (r_lock_vld && !plug_req_i[r_lock_idx]) begin
                r_lock_vld <= 1'b0;
            end
        end
    end

`ifdef SPERIPH_PLUG_ARB_RR_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rr <= '0;
        end else if (w_hs) begin
            r_rr <= (w_win == IDX_W'(NB_PLUGS - 1)) ? '0 : w_win + IDX_W'(1);
        end
    end
`endif

    assign busy_o = (r_count != '0);
    assign err_o  = r_err;

endmodule

// File: tb/tb_speriph_plug_arbiter.sv
// Randomized and directed checking of speriph_plug_arbiter (4 plugs, depth-2 FIFO) against a queue-based model.
module tb_speriph_plug_arbiter;

    localparam int NB   = 4;
    localparam int IDW  = 5;
    localparam int MAXO = 2;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [NB-1:0]             req, wen;
    logic [NB-1:0][31:0]       add, wdata;
    logic [NB-1:0][3:0]        be;
    logic [NB-1:0][IDW-1:0]    id;
    logic [NB-1:0]             gnt_o, rv_o, opc_o;
    logic [NB-1:0][31:0]       rdata_o;
    logic [NB-1:0][IDW-1:0]    rid_o;
    logic                      mreq, mwen;
    logic [31:0]               madd, mwdata;
    logic [3:0]                mbe;
    logic [IDW-1:0]            mid;
    logic                      gnt, rv, ropc;
    logic [31:0]               rrdata;
    logic [IDW-1:0]            rrid;
    logic                      busy, err;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: outstanding plug indices in issue order
    int m_q[$];
    bit m_lock_vld;
    int m_lock;
    int m_rr;
    bit m_err;
    bit s_pop, s_hs;
    int s_win;

    always #5 clk = ~clk;

    speriph_plug_arbiter #(.NB_PLUGS(NB), .ID_WIDTH(IDW), .MAX_OUTSTANDING(MAXO)) dut (
        .clk_i(clk), .rst_i(rst),
        .plug_req_i(req), .plug_wen_i(wen), .plug_add_i(add), .plug_wdata_i(wdata),
        .plug_be_i(be), .plug_id_i(id),
        .plug_gnt_o(gnt_o), .plug_r_valid_o(rv_o), .plug_r_opc_o(opc_o),
        .plug_r_rdata_o(rdata_o), .plug_r_id_o(rid_o),
        .mst_req_o(mreq), .mst_wen_o(mwen), .mst_add_o(madd), .mst_wdata_o(mwdata),
        .mst_be_o(mbe), .mst_id_o(mid),
        .mst_gnt_i(gnt), .mst_r_valid_i(rv), .mst_r_opc_i(ropc), .mst_r_rdata_i(rrdata),
        .mst_r_id_i(rrid),
        .busy_o(busy), .err_o(err)
    );

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int m_winner();
        if (m_lock_vld && req[m_lock]) return m_lock;
`ifdef SPERIPH_PLUG_ARB_RR_EN
        for (int k = 0; k < NB; k++) if (req[(m_rr + k) % NB]) return (m_rr + k) % NB;
`else
        for (int i = 0; i < NB; i++) if (req[i]) return i;
`endif
        return 0;
    endfunction

    // Compare every DUT output against the model, mid-cycle
    task automatic settle();
        logic [NB-1:0]          e_gnt, e_rv, e_opc;
        logic [NB-1:0][31:0]    e_rd;
        logic [NB-1:0][IDW-1:0] e_id;
        bit ereq, full;
        @(negedge clk);
        s_pop = rv && (m_q.size() > 0);
        full  = (m_q.size() == MAXO) && !s_pop;
        ereq  = (req != '0) && !full;
        s_win = m_winner();
        s_hs  = ereq && gnt;
        e_gnt = '0; e_rv = '0; e_opc = '0; e_rd = '0; e_id = '0;
        if (s_hs) e_gnt[s_win] = 1'b1;
        if (s_pop) begin
            e_rv[m_q[0]]  = 1'b1;
            e_opc[m_q[0]] = ropc;
            e_rd[m_q[0]]  = rrdata;
            e_id[m_q[0]]  = rrid;
        end
        check_val("mst_req",   128'(mreq),   128'(ereq));
        check_val("mst_add",   128'(madd),   ereq ? 128'(add[s_win])   : 128'd0);
        check_val("mst_wen",   128'(mwen),   ereq ? 128'(wen[s_win])   : 128'd0);
        check_val("mst_wdata", 128'(mwdata), ereq ? 128'(wdata[s_win]) : 128'd0);
        check_val("mst_be",    128'(mbe),    ereq ? 128'(be[s_win])    : 128'd0);
        check_val("mst_id",    128'(mid),    ereq ? 128'(id[s_win])    : 128'd0);
        check_val("plug_gnt",  128'(gnt_o),  128'(e_gnt));
        check_val("r_valid",   128'(rv_o),   128'(e_rv));
        check_val("r_opc",     128'(opc_o),  128'(e_opc));
        check_val("r_rdata",   128'(rdata_o), 128'(e_rd));
        check_val("r_id",      128'(rid_o),  128'(e_id));
        check_val("busy",      128'(busy),   128'(m_q.size() != 0));
        check_val("err",       128'(err),    128'(m_err));
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        if (rst) begin
            m_q.delete();
            m_lock_vld = 1'b0;
            m_rr = 0;
            m_err = 1'b0;
        end else begin
            m_err = rv && (m_q.size() == 0);
            if (s_pop) void'(m_q.pop_front());
            if (s_hs) begin
                m_q.push_back(s_win);
                m_rr = (s_win + 1) % NB;
                m_lock_vld = 1'b0;
            end else if ((req != '0) && ((m_q.size() < MAXO) || s_pop)) begin
                m_lock_vld = 1'b1;
                m_lock = s_win;
            end else if (m_lock_vld && !req[m_lock]) begin
                m_lock_vld = 1'b0;
            end
        end
    endtask

    task automatic cycle();
        settle();
        advance();
    endtask

    task automatic randomize_payload();
        for (int p = 0; p < NB; p++) begin
            add[p]   = $urandom;
            wdata[p] = $urandom;
            be[p]    = 4'($urandom);
            id[p]    = IDW'($urandom);
        end
        wen    = NB'($urandom);
        ropc   = 1'($urandom);
        rrdata = $urandom;
        rrid   = IDW'($urandom);
    endtask

    task automatic drain(input int n);
        req = '0; gnt = 1'b0; rv = 1'b1;
        repeat (n) cycle();
        rv = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req = '0; gnt = 1'b0; rv = 1'b0;
        randomize_payload();
        @(posedge clk); #1;
        m_q.delete(); m_lock_vld = 1'b0; m_rr = 0; m_err = 1'b0;
        settle();
        check_val("rst_busy", 128'(busy), 128'd0);
        check_val("rst_err",  128'(err),  128'd0);
        advance();
        rst = 1'b0;

        // All plugs requesting with immediate grants
        req = 4'hF; gnt = 1'b1; rv = 1'b1;
        for (int c = 0; c < 5; c++) begin
            randomize_payload();
            settle();
`ifdef SPERIPH_PLUG_ARB_RR_EN
            check_val("all_req_order", 128'(gnt_o), 128'(1 << (c % NB)));
`else
            check_val("all_req_order", 128'(gnt_o), 128'd1);
`endif
            advance();
        end
        drain(3);

        // Single requester on plug1, then its response
        req = 4'b0010; gnt = 1'b1; rv = 1'b0;
        settle();
        check_val("p1_add", 128'(madd),  128'(add[1]));
        check_val("p1_gnt", 128'(gnt_o), 128'(4'b0010));
        advance();
        req = '0; rv = 1'b1;
        settle();
        check_val("p1_resp", 128'(rv_o), 128'(4'b0010));
        advance();
        rv = 1'b0;

        // Fill the FIFO, then a response frees a slot in the same cycle
        req = 4'b0010; gnt = 1'b1;
        cycle(); cycle();
        settle();
        check_val("full_req", 128'(mreq), 128'd0);
        advance();
        rv = 1'b1;
        settle();
        check_val("pop_req", 128'(mreq), 128'd1);
        advance();
        drain(4);

        // Stalled plug2 keeps the slot while plug0 joins
        req = 4'b0100; gnt = 1'b0;
        cycle();
        req = 4'b0101;
        cycle(); cycle();
        gnt = 1'b1;
        settle();
        check_val("lock_gnt", 128'(gnt_o), 128'(4'b0100));
        advance();
        drain(3);

        // Orphan response
        rv = 1'b1; req = '0; gnt = 1'b0;
        settle();
        check_val("orphan_rv", 128'(rv_o), 128'd0);
        advance();
        rv = 1'b0;
        settle();
        check_val("orphan_err", 128'(err), 128'd1);
        advance();
        settle();
        check_val("orphan_err_clr", 128'(err), 128'd0);
        advance();

        // Reset with two outstanding
        req = 4'b0001; gnt = 1'b1;
        cycle(); cycle();
        req = '0; rst = 1'b1;
        cycle();
        rst = 1'b0;
        settle();
        check_val("rst_mid_busy", 128'(busy), 128'd0);
        advance();
        rv = 1'b1;
        cycle();
        rv = 1'b0;
        settle();
        check_val("rst_mid_err", 128'(err), 128'd1);
        advance();

        // Random traffic with occasional reset
        for (int n = 0; n < 3000; n++) begin
            randomize_payload();
            rst = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 1) == 0) req = NB'($urandom);
            gnt = ($urandom_range(0, 2) != 0);
            rv  = ($urandom_range(0, 2) == 0);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/speriph_plug_arbiter.md
SPERIPH_PLUG_ARBITER -- requirements
Module: speriph_plug_arbiter

Interface
REQ-001 SHALL have parameter NB_PLUGS, default 2, number of slave plugs merged onto one peripheral target (legal range 1..16).
REQ-002 SHALL have parameter ID_WIDTH, default 5, width of the request and response id fields.
REQ-003 SHALL have parameter MAX_OUTSTANDING, default 2, depth of the response-routing FIFO (legal range 1..8).
REQ-004 SHALL have ports clk_i  in  1  clock; rst_i  in  1  reset (one clock; reset is synchronous and active-high).
REQ-005 SHALL have ports plug_req_i, plug_wen_i  in  NB_PLUGS  per-plug request and write-enable (wen=0 means write).
REQ-006 SHALL have ports plug_add_i, plug_wdata_i  in  NB_PLUGS x 32  per-plug address and write data.
REQ-007 SHALL have ports plug_be_i  in  NB_PLUGS x 4  byte enables; plug_id_i  in  NB_PLUGS x ID_WIDTH  request id.
REQ-008 SHALL have ports plug_gnt_o, plug_r_valid_o, plug_r_opc_o  out  NB_PLUGS  per-plug grant, response valid and response error.
REQ-009 SHALL have ports plug_r_rdata_o  out  NB_PLUGS x 32 and plug_r_id_o  out  NB_PLUGS x ID_WIDTH  per-plug response data and id.
REQ-010 SHALL have master ports mst_req_o, mst_wen_o  out  1; mst_add_o, mst_wdata_o  out  32; mst_be_o  out  4; mst_id_o  out  ID_WIDTH.
REQ-011 SHALL have master ports mst_gnt_i, mst_r_valid_i, mst_r_opc_i  in  1; mst_r_rdata_i  in  32; mst_r_id_i  in  ID_WIDTH.
REQ-012 SHALL have ports busy_o  out  1  FIFO non-empty; err_o  out  1  one-cycle pulse on orphan response.

Function
REQ-013 Winner selection SHALL be combinational over plug_req_i; mst_req_o = 1 iff some plug requests and the FIFO is not full.
REQ-014 mst_add_o/wen_o/wdata_o/be_o/id_o SHALL carry the winner's fields; all are 0 when mst_req_o=0.
REQ-015 plug_gnt_o[w] SHALL equal mst_gnt_i & mst_req_o for winner w only; all other bits 0, with no added latency.
REQ-016 A request that is asserted but not granted SHALL keep the same winner on subsequent cycles (lock register) until req&gnt occurs or that plug drops req.
REQ-017 On handshake (mst_req_o & mst_gnt_i) the winner index SHALL be pushed into the routing FIFO in the same cycle.
REQ-018 mst_r_valid_i SHALL be routed combinationally to the plug at the FIFO head, along with r_rdata, r_opc and r_id; the FIFO pops that cycle; non-head plugs see r_valid=0 and zero data.
REQ-019 Simultaneous push and pop SHALL keep the count unchanged; push when full SHALL be impossible by REQ-013.
REQ-020 mst_r_valid_i with an empty FIFO SHALL be dropped and SHALL pulse err_o for one cycle.
REQ-021 Responses SHALL be assumed to return in order; FIFO pointers SHALL wrap modulo MAX_OUTSTANDING.

Reset
REQ-022 On rst_i=1 at a clock edge: FIFO count and pointers = 0, lock invalid, round-robin pointer = 0, err_o = 0, busy_o = 0.
REQ-023 Reset mid-transaction SHALL discard all pending routing entries; responses arriving after reset SHALL be treated as orphans (REQ-020).

Configuration
REQ-024 Macro SPERIPH_PLUG_ARB_RR_EN defined: round-robin arbitration; search starts at pointer rr_q, and on each handshake rr_q <= (winner+1) mod NB_PLUGS.
REQ-025 Macro undefined: fixed priority with the lowest requesting index winning; rr_q is not implemented; lock behaviour (REQ-016) is unchanged.

Verification
REQ-026 NB_PLUGS=2, only plug1 requests with mst_gnt_i=1 -> mst_add_o=plug1 address, plug_gnt_o=2'b10, FIFO head=1, response routed to plug1 only.
REQ-027 RR_EN, NB_PLUGS=4, all plugs requesting continuously, gnt=1 -> grant order 0,1,2,3,0; without the macro -> plug0 on every cycle.
REQ-028 Plug2 requests, mst_gnt_i=0 for 3 cycles while plug0 starts requesting -> winner stays plug2; plug2 is granted on cycle 4.
REQ-029 MAX_OUTSTANDING=2, two grants with no response -> mst_req_o=0 on the 3rd cycle; one r_valid -> mst_req_o=1 in the same cycle.
REQ-030 mst_r_valid_i=1 with empty FIFO -> err_o=1 for exactly one cycle, all plug_r_valid_o=0.
REQ-031 rst_i asserted with 2 outstanding -> busy_o=0 the next cycle; a following response pulses err_o.
